// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sar_search_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search_flag_chk.sv
// Checks that the comparator flags {cmp_e, cmp_g, cmp_l} are exactly one-hot.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module flag_chk (
  input  logic [2:0] i_flags,
  output logic       o_onehot
);

  // Exactly one of equal / greater / less may be asserted
  always_comb begin
    o_onehot = 1'b0;
    case (i_flags)
      3'b001, 3'b010, 3'b100: o_onehot = 1'b1;
      default:                o_onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/sar_search.sv
// Binary (SAR) search for a target value using an external magnitude comparator.
// Latency: one probe per bit, at most W probes; done at most W+1 cycles after start.
// Backpressure: each probe holds guess until cmp_valid; start ignored while not IDLE.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] guess,
  output logic         guess_valid,
  input  logic         cmp_valid,
  input  logic         cmp_e,
  input  logic         cmp_g,
  input  logic         cmp_l,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int KW = $clog2(W);

  state_t         r_state;
  logic [KW-1:0]  r_k;
  logic [W-1:0]   r_guess;
  logic           r_guess_valid;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_result;
  logic           r_err;

  logic           w_onehot;
  logic [W-1:0]   w_bit_k;
  logic [W-1:0]   w_bit_km1;
  logic           w_k_zero;

  flag_chk u_flag_chk (
    .i_flags  ({cmp_e, cmp_g, cmp_l}),
    .o_onehot (w_onehot)
  );

  // Masks for the bit under test and the next bit down
  assign w_bit_k   = {{(W-1){1'b0}}, 1'b1} << r_k;
  assign w_bit_km1 = w_bit_k >> 1;
  assign w_k_zero  = (r_k == '0);

  // Search FSM: all outputs registered; guess is zeroed outside PROBE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_k           <= '0;
      r_guess       <= '0;
      r_guess_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state       <= PROBE;
            r_k           <= KW'(W-1);
            r_guess       <= {1'b1, {(W-1){1'b0}}};
            r_guess_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_result      <= '0;
            r_err         <= 1'b0;
          end
        end

        PROBE: begin
          if (cmp_valid) begin
            if (!w_onehot) begin
              // Inconsistent comparator answer: abort
              r_state       <= DONE;
              r_result      <= '0;
              r_err         <= 1'b1;
              r_done        <= 1'b1;
              r_busy        <= 1'b0;
              r_guess_valid <= 1'b0;
              r_guess       <= '0;
              r_k           <= '0;
            end else if (cmp_e) begin
              r_state       <= DONE;
              r_result      <= r_guess;
              r_err         <= 1'b0;
              r_done        <= 1'b1;
              r_busy        <= 1'b0;
              r_guess_valid <= 1'b0;
              r_guess       <= '0;
              r_k           <= '0;
            end else if (cmp_g) begin
              if (w_k_zero) begin
                // Target above every representable candidate on this path
                r_state       <= DONE;
                r_result      <= '0;
                r_err         <= 1'b1;
                r_done        <= 1'b1;
                r_busy        <= 1'b0;
                r_guess_valid <= 1'b0;
                r_guess       <= '0;
                r_k           <= '0;
              end else begin
                r_guess <= r_guess | w_bit_km1;
                r_k     <= r_k - KW'(1);
              end
            end else begin
              if (w_k_zero) begin
                // Last bit resolved low: answer is guess with bit 0 cleared
                r_state       <= DONE;
                r_result      <= r_guess & ~{{(W-1){1'b0}}, 1'b1};
                r_err         <= 1'b0;
                r_done        <= 1'b1;
                r_busy        <= 1'b0;
                r_guess_valid <= 1'b0;
                r_guess       <= '0;
                r_k           <= '0;
              end else begin
                r_guess <= (r_guess & ~w_bit_k) | w_bit_km1;
                r_k     <= r_k - KW'(1);
              end
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state       <= IDLE;
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_guess_valid <= 1'b0;
          r_guess       <= '0;
        end
      endcase
    end
  end

  assign guess       = r_guess;
  assign guess_valid = r_guess_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign err         = r_err;

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: W, default 4, operand width in bits (W >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 guess  output  W  candidate value driven to the external magnitude comparator.
REQ-006 guess_valid  output  1  guess is stable and awaiting a comparison result.
REQ-007 cmp_valid  input  1  cmp_e/cmp_g/cmp_l are valid this cycle.
REQ-008 cmp_e  input  1  target == guess.
REQ-009 cmp_g  input  1  target > guess.
REQ-010 cmp_l  input  1  target < guess.
REQ-011 busy  output  1  a search is in progress.
REQ-012 done  output  1  one-cycle pulse; the search has finished.
REQ-013 result  output  W  found value; held from done until the next accepted start.
REQ-014 err  output  1  the last search aborted on inconsistent flags; held like result.

Function
REQ-015 FSM states SHALL be IDLE, PROBE and DONE.
REQ-016 IDLE with start=1 SHALL go to PROBE, set bit pointer k=W-1 and set guess=1<<(W-1); busy=1 from the next cycle.
REQ-017 In PROBE: guess_valid=1, and guess, k and state SHALL hold while cmp_valid=0.
REQ-018 PROBE with cmp_valid=1 and cmp_e=1 (flags one-hot) SHALL load result=guess, set err=0 and go to DONE.
REQ-019 PROBE with cmp_valid=1, cmp_g=1 and k>0: keep bit k, set bit k-1, k<=k-1, stay in PROBE.
REQ-020 PROBE with cmp_valid=1, cmp_l=1 and k>0: clear bit k, set bit k-1, k<=k-1, stay in PROBE.
REQ-021 PROBE with cmp_l=1 and k=0: result=guess with bit 0 cleared, err=0, go to DONE.
REQ-022 PROBE with cmp_g=1 and k=0 is out of range: result=0, err=1, go to DONE.
REQ-023 Flags not exactly one-hot when cmp_valid=1: result=0, err=1, go to DONE.
REQ-024 DONE SHALL assert done=1 with busy=0 and guess_valid=0 for exactly one cycle, then go to IDLE.
REQ-025 start SHALL be ignored in PROBE and DONE; no queuing.
REQ-026 Probe count per search: at most W. With cmp_valid tied high, done rises at most W+1 cycles after the start cycle.
REQ-027 guess SHALL read 0 whenever guess_valid=0.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and clear guess, guess_valid, busy, done, result, err and k, including in mid-PROBE.
REQ-029 After reset release, the first start SHALL begin a clean search with no residue from the aborted one.

Structure
REQ-030 Package sar_search_pkg SHALL hold the state enum (IDLE, PROBE, DONE) and the default width constant W_DEF=4.
REQ-031 A sub-module flag_chk SHALL perform the one-hot check on {cmp_e, cmp_g, cmp_l}; everything else stays in sar_search.

Verification
The bench models the comparator combinationally against a target, with cmp_valid=1 unless stated and W=4.
REQ-032 target=9 -> guesses 8(G), 12(L), 10(L), 9(E); done 5 cycles after start; result=9, err=0.
REQ-033 target=0 -> guesses 8, 4, 2, 1, all L; result=0, err=0, done after 4 probes.
REQ-034 target=15 -> guesses 8(G), 12(G), 14(G), 15(E); result=15. Forced cmp_g=1 on guess=15 -> result=0, err=1.
REQ-035 cmp_e=cmp_g=1 on the first probe -> err=1, result=0, done pulses one cycle later; all-zero flags with cmp_valid=1 behave the same.
REQ-036 target=6 with cmp_valid asserted 3 cycles after each guess -> guess stable while waiting, result=6; a start pulse during the search is ignored.
REQ-037 rst_n low mid-PROBE -> all outputs 0 asynchronously; a new search for target=3 after release returns result=3.
